// File: rtl/irq_pending_arbiter16.sv
// irq_pending_arbiter16
// Captures 16 request lines into pending bits, applies an enable mask and
// presents the highest-priority enabled pending line (bit 15 highest) as a
// registered 4-bit ID.
//
// Handshake: o_id_valid/o_id are registered and held stable while
// o_id_valid=1 and i_id_ready=0. A transfer occurs on a rising edge where
// o_id_valid=1 and i_id_ready=1. At that edge the granted pending bit
// clears unless it is set again at the same edge. i_id_ready is a don't-care
// while o_id_valid=0. After each transfer there is one idle cycle before the
// next ID can be presented.
module irq_pending_arbiter16 #(
   parameter bit          EDGE_MODE  = 1'b1,
   parameter logic [15:0] RESET_MASK = 16'hFFFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_req,
   input  logic        i_mask_wr,
   input  logic [15:0] i_mask_in,
   input  logic        i_id_ready,
   input  logic        i_ovf_clr,
   output logic        o_id_valid,
   output logic [3:0]  o_id,
   output logic [15:0] o_pending,
   output logic [15:0] o_ovf,
   output logic        o_state
);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_req_q;
   logic [15:0] r_pending;
   logic [15:0] r_ovf;
   logic [15:0] r_mask;
   logic [3:0]  r_id;
   logic        r_id_valid;

   logic [15:0] w_edge;
   logic [15:0] w_masked;
   logic        w_accept;
   logic [15:0] w_clr_vec;
   logic [15:0] w_ovf_set;
   logic [3:0]  w_top_id;
   logic [3:0]  w_id_nxt;
   logic        w_id_valid_nxt;

   // Set events: rising edges of req in edge mode, raw level otherwise.
   assign w_edge    = EDGE_MODE ? (i_req & ~r_req_q) : i_req;
   assign w_masked  = r_pending & r_mask;
   assign w_accept  = (r_state == S_PRESENT) && i_id_ready;
   assign w_clr_vec = w_accept ? (16'h0001 << r_id) : 16'h0000;
   // A second set arriving on a line still pending (and not being cleared
   // now) loses an event; only meaningful when counting edges.
   assign w_ovf_set = EDGE_MODE ? (w_edge & r_pending & ~w_clr_vec) : 16'h0000;

   // Priority encoder: highest set bit of the enabled pending vector.
   always_comb begin
      w_top_id = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_masked[i]) begin
            w_top_id = 4'(i);
         end
      end
   end

   // Next-state and grant logic; a presented ID is never preempted.
   always_comb begin
      w_state_nxt    = r_state;
      w_id_nxt       = r_id;
      w_id_valid_nxt = r_id_valid;
      case (r_state)
         S_IDLE: begin
            if (|w_masked) begin
               w_state_nxt    = S_PRESENT;
               w_id_nxt       = w_top_id;
               w_id_valid_nxt = 1'b1;
            end
         end
         S_PRESENT: begin
            if (i_id_ready) begin
               w_state_nxt    = S_IDLE;
               w_id_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_id_valid_nxt = 1'b0;
         end
      endcase
   end

   // FSM state and presented ID registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_id       <= 4'd0;
         r_id_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_id       <= w_id_nxt;
         r_id_valid <= w_id_valid_nxt;
      end
   end

   // Request capture, pending set/clear (set wins) and mask register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_req_q   <= 16'h0000;
         r_pending <= 16'h0000;
         r_mask    <= RESET_MASK;
      end else begin
         r_req_q   <= i_req;
         r_pending <= (r_pending & ~w_clr_vec) | w_edge;
         if (i_mask_wr) begin
            r_mask <= i_mask_in;
         end
      end
   end

   // Sticky overflow flags; a new overflow beats a clear at the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf <= 16'h0000;
      end else begin
         r_ovf <= (i_ovf_clr ? 16'h0000 : r_ovf) | w_ovf_set;
      end
   end

   assign o_id_valid = r_id_valid;
   assign o_id       = r_id;
   assign o_pending  = r_pending;
   assign o_ovf      = r_ovf;
   assign o_state    = r_state;

endmodule

// File: tb/tb_irq_pending_arbiter16.sv
// Directed bench for irq_pending_arbiter16 (EDGE_MODE=1, RESET_MASK=FFFF).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_irq_pending_arbiter16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic        mask_wr;
   logic [15:0] mask_in;
   logic        id_ready;
   logic        ovf_clr;
   logic        id_valid;
   logic [3:0]  id;
   logic [15:0] pending;
   logic [15:0] ovf;
   logic        state;

   int n_cmp = 0;
   int n_err = 0;

   irq_pending_arbiter16 #(
      .EDGE_MODE  (1'b1),
      .RESET_MASK (16'hFFFF)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .i_mask_wr  (mask_wr),
      .i_mask_in  (mask_in),
      .i_id_ready (id_ready),
      .i_ovf_clr  (ovf_clr),
      .o_id_valid (id_valid),
      .o_id       (id),
      .o_pending  (pending),
      .o_ovf      (ovf),
      .o_state    (state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string name, input logic [3:0] exp_id);
      n_cmp++;
      if (id_valid !== 1'b1 || id !== exp_id) begin
         n_err++;
         $display("FAIL %s: valid=%b id=%0d, want valid=1 id=%0d", name, id_valid, id, exp_id);
      end
   endtask

   task automatic chk_idle(input string name, input logic [15:0] exp_pend);
      n_cmp++;
      if (id_valid !== 1'b0 || pending !== exp_pend) begin
         n_err++;
         $display("FAIL %s: valid=%b pending=%h, want valid=0 pending=%h",
                  name, id_valid, pending, exp_pend);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; mask_wr = 1'b0; mask_in = '0; id_ready = 1'b0; ovf_clr = 1'b0;
      step(); step();
      n_cmp++;
      if (id_valid !== 1'b0 || id !== 4'd0 || pending !== 16'h0 || ovf !== 16'h0 || state !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b id=%0d pend=%h ovf=%h st=%b, want all 0",
                  id_valid, id, pending, ovf, state);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_pulse();
      req = 16'h0008;
      step();
      n_cmp++;
      if (pending !== 16'h0008 || id_valid !== 1'b0) begin
         n_err++;
         $display("FAIL pulse_latency1: pend=%h valid=%b, want pend=0008 valid=0", pending, id_valid);
      end
      req = 16'h0000;
      step();
      chk_grant("pulse_grant3", 4'd3);
      id_ready = 1'b1;
      step();
      chk_idle("pulse_accept", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      req = 16'h2204;
      step();
      req = 16'h0000; id_ready = 1'b1;
      step(); chk_grant("b2b_grant13", 4'd13);
      step(); chk_idle("b2b_gap1", 16'h0204);
      step(); chk_grant("b2b_grant9", 4'd9);
      step(); chk_idle("b2b_gap2", 16'h0004);
      step(); chk_grant("b2b_grant2", 4'd2);
      step(); chk_idle("b2b_done", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_hold_no_preempt();
      req = 16'h0020;
      step();
      req = 16'h0000;
      step(); chk_grant("hold_grant5", 4'd5);
      for (int c = 0; c < 6; c++) begin
         req = 16'h8000;
         step();
         chk_grant("hold_stable5", 4'd5);
      end
      req = 16'h0000;
      n_cmp++;
      if (pending !== 16'h8020) begin
         n_err++;
         $display("FAIL hold_pending: pend=%h, want 8020", pending);
      end
      id_ready = 1'b1;
      step(); chk_idle("hold_accept", 16'h8000);
      step(); chk_grant("hold_next15", 4'd15);
      step(); chk_idle("hold_done", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_mask();
      mask_wr = 1'b1; mask_in = 16'h7FFF;
      step();
      mask_wr = 1'b0;
      req = 16'h8002;
      step();
      req = 16'h0000;
      step(); chk_grant("mask_grant1", 4'd1);
      id_ready = 1'b1;
      step(); chk_idle("mask_accept1", 16'h8000);
      id_ready = 1'b0;
      step(); chk_idle("mask_blocks15", 16'h8000);
      mask_wr = 1'b1; mask_in = 16'hFFFF;
      step(); chk_idle("mask_load_edge", 16'h8000);
      mask_wr = 1'b0;
      step(); chk_grant("mask_grant15", 4'd15);
      id_ready = 1'b1;
      step(); chk_idle("mask_accept15", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      req = 16'h0080;
      step();
      req = 16'h0000;
      step(); chk_grant("ovf_grant7", 4'd7);
      req = 16'h0080;
      step();
      req = 16'h0000;
      n_cmp++;
      if (ovf !== 16'h0080) begin
         n_err++;
         $display("FAIL ovf_set: ovf=%h, want 0080", ovf);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      n_cmp++;
      if (ovf !== 16'h0000) begin
         n_err++;
         $display("FAIL ovf_clear: ovf=%h, want 0000", ovf);
      end
      id_ready = 1'b1;
      step(); chk_idle("ovf_accept", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_idle_ready();
      id_ready = 1'b1;
      step(); chk_idle("idle_ready_ignored", 16'h0000);
      req = 16'h0010;
      step();
      req = 16'h0000;
      step(); chk_grant("idle_ready_grant4", 4'd4);
      step(); chk_idle("idle_ready_accept", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   task automatic test_reset_inflight();
      mask_wr = 1'b1; mask_in = 16'h7FFF;
      step();
      mask_wr = 1'b0;
      req = 16'h0400;
      step();
      req = 16'h0000;
      step();
      req = 16'h8400;
      step();
      req = 16'h0000;
      n_cmp++;
      if (id_valid !== 1'b1 || id !== 4'd10 || ovf !== 16'h0400 || pending !== 16'h8400) begin
         n_err++;
         $display("FAIL rst_setup: valid=%b id=%0d ovf=%h pend=%h, want 1 10 0400 8400",
                  id_valid, id, ovf, pending);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (id_valid !== 1'b0 || id !== 4'd0 || pending !== 16'h0 || ovf !== 16'h0 || state !== 1'b0) begin
         n_err++;
         $display("FAIL rst_inflight: valid=%b id=%0d pend=%h ovf=%h st=%b, want all 0",
                  id_valid, id, pending, ovf, state);
      end
      // Mask must be back to FFFF: line 15 is grantable again.
      req = 16'h8000;
      step();
      req = 16'h0000;
      step(); chk_grant("rst_mask_restored", 4'd15);
      id_ready = 1'b1;
      step(); chk_idle("rst_final_accept", 16'h0000);
      id_ready = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_back_to_back();
      test_hold_no_preempt();
      test_mask();
      test_overflow();
      test_idle_ready();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
